// File: rtl/deemphasis.sv
// First-order IIR de-emphasis y[n] = x[n] + a*y[n-1] with a valid/ready stream and one output register.
// Define DEEMPHASIS_SAT_EN to clip to the output range; otherwise the result wraps and sat_o is 0.
module deemphasis #(
  parameter int I_BW    = 17,
  parameter int O_BW    = 16,
  parameter int COEF_BW = 16,
  parameter int COEF    = 31785
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   sof_i,
  input  logic signed [I_BW-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic signed [O_BW-1:0] data_o,
  output logic                   sat_o
);

  localparam int S_BW = ((I_BW > O_BW) ? I_BW : O_BW) + 2;
  localparam int P_BW = O_BW + COEF_BW;
  localparam logic signed [COEF_BW-1:0] COEF_S = COEF_BW'(COEF);
  localparam logic signed [P_BW-1:0]    HALF   = P_BW'(1) << (COEF_BW - 2);

  // Round-half-up of the Q1.(COEF_BW-1) product back to integer scale.
  function automatic logic signed [S_BW-1:0] round_shift(input logic signed [P_BW-1:0] prod);
    logic signed [P_BW-1:0] biased;
    biased = prod + HALF;
    return S_BW'(biased >>> (COEF_BW - 1));
  endfunction

`ifdef DEEMPHASIS_SAT_EN
  localparam logic signed [S_BW-1:0] Y_MAX = S_BW'((1 << (O_BW - 1)) - 1);
  localparam logic signed [S_BW-1:0] Y_MIN = S_BW'(-(1 << (O_BW - 1)));

  // Returns {clip_flag, clipped_value}.
  function automatic logic [O_BW:0] saturate(input logic signed [S_BW-1:0] v);
    if (v > Y_MAX)      return {1'b1, O_BW'(Y_MAX)};
    else if (v < Y_MIN) return {1'b1, O_BW'(Y_MIN)};
    else                return {1'b0, O_BW'(v)};
  endfunction
`endif

  logic                   acc;
  logic signed [O_BW-1:0] y_prev;
  logic signed [O_BW-1:0] h;
  logic signed [P_BW-1:0] p;
  logic signed [S_BW-1:0] f;
  logic signed [S_BW-1:0] s;
  logic signed [O_BW-1:0] y;
  logic                   clip;

  assign ready_o = !valid_o || ready_i;
  assign acc     = valid_i && ready_o;

  // Single-cycle feedback datapath: multiply, round, add, clip/wrap.
  always_comb begin
    h = sof_i ? '0 : y_prev;
    p = P_BW'(COEF_S) * P_BW'(h);
    f = round_shift(p);
    s = S_BW'(data_i) + f;
`ifdef DEEMPHASIS_SAT_EN
    {clip, y} = saturate(s);
`else
    clip = 1'b0;
    y    = O_BW'(s);
`endif
  end

  // Output register and filter history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      y_prev  <= '0;
    end else if (acc) begin
      valid_o <= 1'b1;
      data_o  <= y;
      y_prev  <= y;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef DEEMPHASIS_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sat_o <= 1'b0;
    else if (acc) sat_o <= clip;
  end
`else
  assign sat_o = 1'b0;
  logic unused_clip;
  assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_deemphasis.sv
// Directed bench for deemphasis: impulse responses, frame restart, backpressure, overflow and reset.
module tb_deemphasis;

  logic               clk;
  logic               rst_n;
  logic               valid_i;
  logic               ready_o;
  logic               sof_i;
  logic signed [16:0] data_i;
  logic               valid_o;
  logic               ready_i;
  logic signed [15:0] data_o;
  logic               sat_o;

  int checks = 0;
  int errors = 0;

  deemphasis dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sof_i   (sof_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .sat_o   (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for exactly one edge (ready_o assumed high).
  task automatic send(input int x, input logic sof);
    valid_i = 1'b1;
    data_i  = 17'(x);
    sof_i   = sof;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (data_o !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d expected 0", data_o); end
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat got %b expected 0", sat_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_impulse;
    int xs [3];
    logic signed [15:0] exp_y [3];
    xs = '{1000, 0, 0};
    exp_y = '{16'sd1000, 16'sd970, 16'sd941};
    for (int i = 0; i < 3; i++) begin
      send(xs[i], i == 0);
      checks++; if (data_o !== exp_y[i]) begin errors++; $display("FAIL impulse_data[%0d] got %0d expected %0d", i, data_o, exp_y[i]); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL impulse_valid[%0d] got %b expected 1", i, valid_o); end
      checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL impulse_sat[%0d] got %b expected 0", i, sat_o); end
    end
  endtask

  task automatic test_frame_restart;
    send(0, 1'b1);
    checks++; if (data_o !== 16'sd0) begin errors++; $display("FAIL restart_data got %0d expected 0", data_o); end
  endtask

  task automatic test_negative;
    send(-1000, 1'b1);
    checks++; if (data_o !== -16'sd1000) begin errors++; $display("FAIL neg_data0 got %0d expected -1000", data_o); end
    send(0, 1'b0);
    checks++; if (data_o !== -16'sd970) begin errors++; $display("FAIL neg_data1 got %0d expected -970", data_o); end
  endtask

  task automatic test_backpressure;
    send(500, 1'b1);
    checks++; if (data_o !== 16'sd500) begin errors++; $display("FAIL bp_first got %0d expected 500", data_o); end
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 17'sd500;
    sof_i   = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b expected 0", ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (data_o !== 16'sd500) begin errors++; $display("FAIL bp_hold_data[%0d] got %0d expected 500", i, data_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b expected 1", i, valid_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d] got %b expected 0", i, ready_o); end
    end
    ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_high got %b expected 1", ready_o); end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    // 500 + round(0.97 * 500) = 985 only if the history stayed at 500.
    checks++; if (data_o !== 16'sd985) begin errors++; $display("FAIL bp_release_data got %0d expected 985", data_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b expected 1", valid_o); end
    @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b expected 0", valid_o); end
    checks++; if (data_o !== 16'sd985) begin errors++; $display("FAIL bp_drain_data got %0d expected 985", data_o); end
  endtask

  task automatic test_overflow;
    send(65535, 1'b1);
`ifdef DEEMPHASIS_SAT_EN
    checks++; if (data_o !== 16'sd32767) begin errors++; $display("FAIL ovf_data got %0d expected 32767", data_o); end
    checks++; if (sat_o !== 1'b1) begin errors++; $display("FAIL ovf_sat got %b expected 1", sat_o); end
`else
    checks++; if (data_o !== -16'sd1) begin errors++; $display("FAIL ovf_data got %0d expected -1", data_o); end
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL ovf_sat got %b expected 0", sat_o); end
`endif
  endtask

  task automatic test_reset_mid;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b expected 1", valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", valid_o); end
    checks++; if (data_o !== 16'sd0) begin errors++; $display("FAIL rstmid_data got %0d expected 0", data_o); end
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL rstmid_sat got %b expected 0", sat_o); end
    @(negedge clk);
    rst_n = 1'b1;
    send(100, 1'b0);
    checks++; if (data_o !== 16'sd100) begin errors++; $display("FAIL rstmid_after got %0d expected 100", data_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_after_valid got %b expected 1", valid_o); end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    test_reset;
    test_impulse;
    test_frame_restart;
    test_negative;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deemphasis.md
# deemphasis

Inverse of the pre-emphasis stage: a first-order IIR de-emphasis filter, y[n] = x[n] + a·y[n-1], with `a` a fixed-point coefficient. It accepts the 17-bit pre-emphasised sample stream and reconstructs 16-bit PCM. It sits on the resynthesis and verification path of the log-mel front end and is used to close the loop against the pre-emphasis output. Streaming uses a valid/ready handshake with one registered output stage, and a start-of-frame input clears the filter history.

## Interface
- I_BW, 17, signed input width (pre-emphasis output width)
- O_BW, 16, signed output width
- COEF_BW, 16, coefficient width, signed Q1.(COEF_BW-1)
- COEF, 31785, coefficient `a` (0.97 in Q1.15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  input sample valid
- ready_o  out  1  block can accept a sample this cycle
- sof_i  in  1  first sample of a frame; qualified by valid_i
- data_i  in  I_BW  signed input sample x[n]
- valid_o  out  1  data_o holds a valid sample
- ready_i  in  1  downstream accepts data_o
- data_o  out  O_BW  signed output sample y[n]
- sat_o  out  1  data_o for this sample was clipped; qualified by valid_o

## Operation
- Accept: `acc = valid_i && ready_o`. Deliver: `valid_o && ready_i`.
- `ready_o = !valid_o || ready_i` (single output register, no skid buffer). It is combinational from ready_i.
- State register `y_prev` (O_BW bits) holds the last emitted y, taken after saturation or wrap.
- On accept:
  - h = 0 if sof_i, else y_prev.
  - p = COEF·h, full product width O_BW+COEF_BW, signed.
  - f = (p + 2^(COEF_BW-2)) >>> (COEF_BW-1). This is arithmetic round-half-up.
  - s = sext(data_i) + f, computed at max(I_BW,O_BW)+2 bits, with no intermediate overflow.
  - y = clip or wrap of s to O_BW (see Configuration).
  - y is loaded into data_o and into y_prev, valid_o is set to 1, and sat_o is loaded with the clip flag.
- No accept and a deliver occur in the same cycle: valid_o is cleared, and data_o, sat_o and y_prev hold.
- No accept and no deliver: all registers hold. data_o stays stable while valid_o=1 and ready_i=0.
- An accept and a deliver in the same cycle give full throughput of 1 sample/clk.
- sof_i is ignored when valid_i=0. A sof_i presented while ready_o=0 takes effect only at the accepting edge.
- No FSM: the two states are output EMPTY (valid_o=0) and FULL (valid_o=1).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on deliver without accept.
  - FULL stays FULL on accept with deliver, or on no deliver.

## Timing
- Reset (asynchronous assert, synchronous release):
  - valid_o=0, data_o=0, sat_o=0, y_prev=0.
  - ready_o=1 after reset.
- Latency: 1 clk. A sample accepted at edge k appears on data_o after edge k with valid_o=1.
- Feedback path is single-cycle: multiply, round, add and clip all complete within one clk, so back-to-back accepts use each other's outputs.
- Reset asserted mid-stream drops the held output and clears the history. The first sample after release behaves as if sof_i=1.

## Configuration
- `DEEMPHASIS_SAT_EN` defined:
  - s > 2^(O_BW-1)-1 gives y = 2^(O_BW-1)-1.
  - s < -2^(O_BW-1) gives y = -2^(O_BW-1).
  - sat_o=1 for that sample.
- `DEEMPHASIS_SAT_EN` undefined:
  - y = s[O_BW-1:0], two's-complement wrap.
  - sat_o is tied to 0, and no comparator logic is generated.

## Test plan
- Impulse, defaults, ready_i=1:
  - Stimulus: x = 1000 (sof=1), 0, 0.
  - Required: data_o = 1000, 970, 941 on consecutive cycles, valid_o held high, sat_o=0.
- Negative impulse:
  - Stimulus: x = -1000 (sof=1), 0.
  - Required: data_o = -1000, -970. This checks arithmetic-shift rounding on negative values.
- Frame restart:
  - Stimulus: after the impulse, x = 0 with sof=1.
  - Required: data_o = 0, with no contribution from the previous 941.
- Backpressure:
  - Stimulus: ready_i=0 for 3 clks while valid_i=1, x=500.
  - Required: ready_o=0, data_o and valid_o stable, y_prev unchanged.
  - On ready_i=1, exactly one sample is delivered per accept, and no samples are lost or duplicated.
- Overflow:
  - Stimulus: x = 65535 with sof=1.
  - With `DEEMPHASIS_SAT_EN`: data_o = 32767, sat_o=1.
  - Without `DEEMPHASIS_SAT_EN`: data_o = -1 (0xFFFF), sat_o=0.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while valid_o=1.
  - Required: valid_o, data_o and sat_o go to 0 immediately.
  - After release, x=100 (sof=0) yields data_o = 100.
